// File: rtl/lzc_rr_arbiter.sv
// lzc_rr_arbiter: round-robin sharing of one leading-zero counter with a 2-stage stallable pipeline
module lzc_core #(
   parameter int    SIZE     = 64,
   parameter int    OUT_SIZE = $clog2(SIZE + 1),
   parameter string FAMILY   = "Agilex"
) (
   input  logic [SIZE-1:0]     din,
   output logic [OUT_SIZE-1:0] count
);
   if (FAMILY != "Agilex" && FAMILY != "Stratix 10") begin : g_bad_family
      $error("lzc_core: unsupported FAMILY");
   end
   // Ascending scan: the highest set bit is the last to write the count
   always_comb begin
      count = OUT_SIZE'(SIZE);
      for (int i = 0; i < SIZE; i++)
         if (din[i]) count = OUT_SIZE'(SIZE - 1 - i);
   end
endmodule

module lzc_rr_arbiter #(
   parameter int    NUM_REQ  = 4,
   parameter int    SIZE     = 64,
   parameter int    OUT_SIZE = $clog2(SIZE + 1),
   parameter int    ID_W     = $clog2(NUM_REQ),
   parameter string FAMILY   = "Agilex"
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*SIZE-1:0] req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [OUT_SIZE-1:0]     rsp_count,
   output logic                    rsp_zero
);
   logic                v1_q, v1_d, v2_q, v2_d, zero2_q, zero2_d;
   logic [ID_W-1:0]     id1_q, id1_d, id2_q, id2_d, ptr_q, ptr_d, win, lo, hi;
   logic [SIZE-1:0]     data1_q, data1_d, win_data, lo_data, hi_data;
   logic [OUT_SIZE-1:0] count2_q, count2_d, count1;
   logic                adv1, adv2, grant, found, found_hi;

   lzc_core #(.SIZE(SIZE), .OUT_SIZE(OUT_SIZE), .FAMILY(FAMILY)) u_lzc (
      .din  (data1_q),
      .count(count1)
   );

   // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index
   always_comb begin
      adv2 = ~(v2_q & ~rsp_ready);
      adv1 = ~v1_q | adv2;
      lo = '0;
      hi = '0;
      lo_data = '0;
      hi_data = '0;
      found = 1'b0;
      found_hi = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo = ID_W'(i);
            lo_data = req_data[i*SIZE +: SIZE];
            found = 1'b1;
         end
         if (req_valid[i] && ID_W'(i) >= ptr_q) begin
            hi = ID_W'(i);
            hi_data = req_data[i*SIZE +: SIZE];
            found_hi = 1'b1;
         end
      end
      win = found_hi ? hi : lo;
      win_data = found_hi ? hi_data : lo_data;
      grant = found & adv1 & rst_n;
      req_ready = grant ? (NUM_REQ'(1) << win) : '0;
      ptr_d = grant ? ((win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1) : ptr_q;
      v1_d = adv1 ? grant : v1_q;
      id1_d = (adv1 && grant) ? win : id1_q;
      data1_d = (adv1 && grant) ? win_data : data1_q;
      v2_d = adv2 ? v1_q : v2_q;
      id2_d = (adv2 && v1_q) ? id1_q : id2_q;
      count2_d = (adv2 && v1_q) ? count1 : count2_q;
      zero2_d = (adv2 && v1_q) ? (count1 == OUT_SIZE'(SIZE)) : zero2_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         ptr_q <= '0;
         id1_q <= '0;
         id2_q <= '0;
         data1_q <= '0;
         count2_q <= '0;
         zero2_q <= 1'b0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         ptr_q <= ptr_d;
         id1_q <= id1_d;
         id2_q <= id2_d;
         data1_q <= data1_d;
         count2_q <= count2_d;
         zero2_q <= zero2_d;
      end
   end

   assign rsp_valid = v2_q;
   assign rsp_id = id2_q;
   assign rsp_count = count2_q;
   assign rsp_zero = zero2_q;
endmodule

// File: tb/tb_lzc_rr_arbiter.sv
// tb_lzc_rr_arbiter: random and directed checks of lzc_rr_arbiter against a queue-based reference model
module tb_lzc_rr_arbiter;
   logic         clk = 1'b0;
   logic         rst_n, rsp_ready, rsp_valid, rsp_zero;
   logic [3:0]   req_valid, req_ready;
   logic [255:0] req_data;
   logic [1:0]   rsp_id;
   logic [6:0]   rsp_count;
   logic         rst3_n, r3_rsp_ready, r3_rsp_valid, r3_rsp_zero;
   logic [2:0]   r3_valid, r3_ready;
   logic [101:0] r3_data;
   logic [1:0]   r3_rsp_id;
   logic [5:0]   r3_rsp_count;

   typedef struct {int id; int cnt; int stage;} item_t;
   item_t       q[$];
   bit          pend[4];
   logic [63:0] pdata[4];
   int          ptr;
   int          n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   lzc_rr_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_count(rsp_count), .rsp_zero(rsp_zero)
   );

   lzc_rr_arbiter #(.NUM_REQ(3), .SIZE(34)) dut3 (
      .clk(clk), .rst_n(rst3_n), .req_valid(r3_valid), .req_data(r3_data),
      .req_ready(r3_ready), .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready),
      .rsp_id(r3_rsp_id), .rsp_count(r3_rsp_count), .rsp_zero(r3_rsp_zero)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_lzc(input logic [63:0] d);
      for (int i = 63; i >= 0; i--)
         if (d[i]) return 63 - i;
      return 64;
   endfunction

   function automatic logic [63:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return 64'h0;
         1: return 64'h8000_0000_0000_0000;
         2: return 64'h1;
         default: return {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
   endfunction

   // One clock: drive at negedge, check, advance the model across the coming posedge
   task automatic step();
      logic [3:0] exp_rdy;
      int win;
      bit vis;
      item_t it;
      for (int i = 0; i < 4; i++) begin
         req_valid[i] = pend[i];
         req_data[i*64 +: 64] = pdata[i];
      end
      #1;
      exp_rdy = '0;
      win = -1;
      if (rst_n && !(q.size() == 2 && !rsp_ready))
         for (int k = 0; k < 4; k++)
            if (win < 0 && pend[(ptr + k) % 4]) win = (ptr + k) % 4;
      if (win >= 0) exp_rdy[win] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      vis = q.size() > 0 && q[0].stage == 2;
      check("rsp_valid", rsp_valid, vis);
      if (vis) begin
         check("rsp_id", rsp_id, q[0].id);
         check("rsp_count", rsp_count, q[0].cnt);
         check("rsp_zero", rsp_zero, q[0].cnt == 64);
      end
      if (!rst_n) begin
         q.delete();
         ptr = 0;
      end else begin
         if (vis && rsp_ready) void'(q.pop_front());
         if (q.size() == 1) q[0].stage = 2;
         if (win >= 0) begin
            it.id = win;
            it.cnt = ref_lzc(pdata[win]);
            it.stage = 1;
            q.push_back(it);
            pend[win] = 1'b0;
            ptr = (win + 1) % 4;
         end
      end
      @(negedge clk);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      logic [2:0] e3;
      rst_n = 1'b0;
      rst3_n = 1'b0;
      rsp_ready = 1'b0;
      r3_rsp_ready = 1'b0;
      r3_valid = '0;
      r3_data = '0;
      req_valid = '0;
      req_data = '0;
      ptr = 0;
      for (int i = 0; i < 4; i++) begin
         pend[i] = 1'b0;
         pdata[i] = '0;
      end
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", rsp_valid, 0);
      check("rst_id", rsp_id, 0);
      check("rst_count", rsp_count, 0);
      check("rst_zero", rsp_zero, 0);
      check("rst_ready", req_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      pend[2] = 1'b1;
      pdata[2] = 64'h0000_0100_0000_0000;
      steps(2);
      #1;
      check("single_id", rsp_id, 2);
      check("single_cnt", rsp_count, 23);
      steps(2);
      pend[1] = 1'b1;
      pend[3] = 1'b1;
      pdata[1] = rnd_op();
      pdata[3] = rnd_op();
      steps(2);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) pdata[i] = rnd_op();
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < 4; i++) pend[i] = 1'b1;
         step();
      end
      steps(6);
      pdata[1] = 64'h8000_0000_0000_0000;
      pend[1] = 1'b1;
      step();
      pdata[1] = 64'h1;
      pend[1] = 1'b1;
      step();
      pdata[1] = 64'h0;
      pend[1] = 1'b1;
      steps(4);
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) pdata[i] = rnd_op();
      pend[0] = 1'b1;
      pend[2] = 1'b1;
      pend[3] = 1'b1;
      steps(5);
      rsp_ready = 1'b1;
      steps(6);
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 4; i++)
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               pdata[i] = rnd_op();
            end
         rsp_ready = $urandom_range(0, 9) < 7;
         rst_n = $urandom_range(0, 99) != 0;
         step();
      end
      rst3_n = 1'b1;
      r3_valid = 3'b111;
      r3_rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         e3 = 3'b001 << (k % 3);
         check("r3_grant", r3_ready, e3);
         check("r3_valid", r3_rsp_valid, k >= 2);
         if (k >= 2) begin
            check("r3_id", r3_rsp_id, (k - 2) % 3);
            check("r3_count", r3_rsp_count, 34);
            check("r3_zero", r3_rsp_zero, 1);
         end
         @(negedge clk);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
